// File: rtl/video_mnist_result_decoder.sv
// video_mnist_result_decoder: 3-stage argmax decoder turning per-pixel class scores into class index + detect flag
// Define VIDEO_MNIST_RESULT_DECODER_SCORE_EN to also emit the winning score in m_axi4s_tdata[15:8].
module video_mnist_result_decoder #(
    parameter int TUSER_WIDTH   = 1,
    parameter int CLASS_NUM     = 10,
    parameter int SCORE_WIDTH   = 7,
    parameter int S_TDATA_WIDTH = CLASS_NUM * SCORE_WIDTH,
    parameter int M_TDATA_WIDTH = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [SCORE_WIDTH-1:0]   param_threshold,
    input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
    input  logic                     s_axi4s_tlast,
    input  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata,
    input  logic                     s_axi4s_tvalid,
    output logic                     s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
    output logic                     m_axi4s_tlast,
    output logic [M_TDATA_WIDTH-1:0] m_axi4s_tdata,
    output logic                     m_axi4s_tvalid,
    input  logic                     m_axi4s_tready
);
    localparam int PAIRS = (CLASS_NUM + 1) / 2;
    localparam int PW    = 2 * PAIRS * SCORE_WIDTH;

    logic                               cke;
    logic [PW-1:0]                      scores;
    logic [SCORE_WIDTH-1:0]             thr_q, thr_d, thr1_q, thr2_q;
    logic                               v1_q, v2_q, v3_q;
    logic                               last1_q, last2_q, last3_q;
    logic [TUSER_WIDTH-1:0]             user1_q, user2_q, user3_q;
    logic [PAIRS-1:0][3:0]              idx1_q, idx1_d;
    logic [PAIRS-1:0][SCORE_WIDTH-1:0]  score1_q, score1_d;
    logic [3:0]                         idx2_q, idx2_d, idx3_q;
    logic [SCORE_WIDTH-1:0]             score2_q, score2_d;
    logic                               det3_q;
    logic                               hi;

    assign cke            = ~v3_q | m_axi4s_tready;
    assign s_axi4s_tready = cke;
    // zero padding gives an odd last class a partner it always beats
    assign scores         = PW'(s_axi4s_tdata[CLASS_NUM*SCORE_WIDTH-1:0]);
    // threshold in force for the beat currently on the input
    assign thr_d          = (s_axi4s_tvalid & s_axi4s_tuser[0]) ? param_threshold : thr_q;

    // pairwise maxima of adjacent classes, lower index wins ties
    always_comb begin
        idx1_d   = '0;
        score1_d = '0;
        hi       = 1'b0;
        for (int i = 0; i < PAIRS; i++) begin
            hi          = scores[(2*i+1)*SCORE_WIDTH +: SCORE_WIDTH] > scores[2*i*SCORE_WIDTH +: SCORE_WIDTH];
            idx1_d[i]   = hi ? 4'(2*i+1) : 4'(2*i);
            score1_d[i] = hi ? scores[(2*i+1)*SCORE_WIDTH +: SCORE_WIDTH] : scores[2*i*SCORE_WIDTH +: SCORE_WIDTH];
        end
    end

    // reduce pair winners in ascending order so strict compare keeps the lowest index
    always_comb begin
        idx2_d   = idx1_q[0];
        score2_d = score1_q[0];
        for (int i = 1; i < PAIRS; i++) begin
            if (score1_q[i] > score2_d) begin
                idx2_d   = idx1_q[i];
                score2_d = score1_q[i];
            end
        end
    end

    // active threshold, updated only by accepted frame-start beats
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) thr_q <= '0;
        else if (cke & s_axi4s_tvalid) thr_q <= thr_d;
    end

    // stage 1: pair maxima plus sideband and per-beat threshold
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            user1_q  <= '0;
            thr1_q   <= '0;
            idx1_q   <= '0;
            score1_q <= '0;
        end else if (cke) begin
            v1_q     <= s_axi4s_tvalid;
            last1_q  <= s_axi4s_tlast;
            user1_q  <= s_axi4s_tuser;
            thr1_q   <= thr_d;
            idx1_q   <= idx1_d;
            score1_q <= score1_d;
        end
    end

    // stage 2: single winner
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v2_q     <= 1'b0;
            last2_q  <= 1'b0;
            user2_q  <= '0;
            thr2_q   <= '0;
            idx2_q   <= '0;
            score2_q <= '0;
        end else if (cke) begin
            v2_q     <= v1_q;
            last2_q  <= last1_q;
            user2_q  <= user1_q;
            thr2_q   <= thr1_q;
            idx2_q   <= idx2_d;
            score2_q <= score2_d;
        end
    end

    // stage 3: output register with threshold decision
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v3_q    <= 1'b0;
            last3_q <= 1'b0;
            user3_q <= '0;
            idx3_q  <= '0;
            det3_q  <= 1'b0;
        end else if (cke) begin
            v3_q    <= v2_q;
            last3_q <= last2_q;
            user3_q <= user2_q;
            idx3_q  <= idx2_q;
            det3_q  <= score2_q >= thr2_q;
        end
    end

`ifdef VIDEO_MNIST_RESULT_DECODER_SCORE_EN
    logic [7:0] score3_q;

    // stage 3 copy of the winning score
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) score3_q <= '0;
        else if (cke) score3_q <= 8'(score2_q);
    end

    assign m_axi4s_tdata = M_TDATA_WIDTH'({score3_q, 3'b000, det3_q, idx3_q});
`else
    assign m_axi4s_tdata = M_TDATA_WIDTH'({8'h00, 3'b000, det3_q, idx3_q});
`endif

    assign m_axi4s_tvalid = v3_q;
    assign m_axi4s_tlast  = last3_q;
    assign m_axi4s_tuser  = user3_q;
endmodule

// File: tb/tb_video_mnist_result_decoder.sv
// tb_video_mnist_result_decoder: scoreboard bench for the argmax result decoder
module tb_video_mnist_result_decoder;
    localparam int CN  = 10;
    localparam int SW  = 7;
    localparam int SDW = CN * SW;

    typedef struct {
        logic [17:0] pkt;
        int          acc;
    } exp_t;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [SW-1:0]  param_threshold = '0;
    logic [0:0]     s_tuser = '0;
    logic           s_tlast = 1'b0;
    logic [SDW-1:0] s_tdata = '0;
    logic           s_tvalid = 1'b0;
    logic           s_tready;
    logic [0:0]     m_tuser;
    logic           m_tlast;
    logic [15:0]    m_tdata;
    logic           m_tvalid;
    logic           m_tready = 1'b1;

    exp_t           exp_q[$];
    logic [SW-1:0]  thr_m = '0;
    int             n_tests = 0;
    int             n_fail = 0;
    int             cyc = 0;
    bit             lat_mode = 1'b1;
    bit             rand_rdy = 1'b0;
    logic [SDW-1:0] d;

    video_mnist_result_decoder dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .param_threshold(param_threshold),
        .s_axi4s_tuser  (s_tuser),
        .s_axi4s_tlast  (s_tlast),
        .s_axi4s_tdata  (s_tdata),
        .s_axi4s_tvalid (s_tvalid),
        .s_axi4s_tready (s_tready),
        .m_axi4s_tuser  (m_tuser),
        .m_axi4s_tlast  (m_tlast),
        .m_axi4s_tdata  (m_tdata),
        .m_axi4s_tvalid (m_tvalid),
        .m_axi4s_tready (m_tready)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference: first strict maximum wins, compare against per-beat threshold
    function automatic logic [17:0] model(input logic [SDW-1:0] v, input logic u, input logic l,
                                          input logic [SW-1:0] thr);
        logic [3:0]    bi;
        logic [SW-1:0] bs;
        logic [7:0]    hi;
        bi = 4'd0;
        bs = v[SW-1:0];
        for (int k = 1; k < CN; k++) begin
            if (v[k*SW +: SW] > bs) begin
                bi = 4'(k);
                bs = v[k*SW +: SW];
            end
        end
`ifdef VIDEO_MNIST_RESULT_DECODER_SCORE_EN
        hi = 8'(bs);
`else
        hi = 8'h00;
`endif
        return {u, l, hi, 3'b000, bs >= thr, bi};
    endfunction

    function automatic logic [SDW-1:0] fill(input int v);
        logic [SDW-1:0] r;
        for (int k = 0; k < CN; k++) r[k*SW +: SW] = SW'(v);
        return r;
    endfunction

    // scoreboard: push on input handshake, pop and compare on output handshake
    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            thr_m <= '0;
        end else begin
            if (m_tvalid && m_tready) begin
                check("exp_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("beat", {m_tuser, m_tlast, m_tdata}, exp_q[0].pkt);
                    if (lat_mode) check("latency", cyc - exp_q[0].acc, 3);
                    void'(exp_q.pop_front());
                end
            end
            if (s_tvalid && s_tready) begin
                exp_q.push_back('{model(s_tdata, s_tuser[0], s_tlast,
                                        s_tuser[0] ? param_threshold : thr_m), cyc});
                if (s_tuser[0]) thr_m <= param_threshold;
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic [SDW-1:0] v, input logic u, input logic l, input logic [SW-1:0] th);
        int w;
        w = 0;
        s_tdata = v;
        s_tuser = u;
        s_tlast = l;
        param_threshold = th;
        s_tvalid = 1'b1;
        do begin
            @(negedge aclk);
            w++;
        end while (!s_tready && w < 200);
        if (!s_tready) check("send_tready", s_tready, 1);
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic wait_out2();
        repeat (2) @(posedge aclk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge aclk);
        #1;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_tuser", m_tuser, 0);
        check("rst_tready", s_tready, 1);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        d = fill(10);
        d[3*SW +: SW] = 7'd100;
        send(d, 1'b1, 1'b0, 7'd64);
        wait_out2();
        check("class3_detect", {m_tvalid, m_tdata[7:0]}, 9'h113);
        d = fill(0);
        d[2*SW +: SW] = 7'd90;
        d[7*SW +: SW] = 7'd90;
        send(d, 1'b0, 1'b0, 7'd0);
        d = fill(20);
        d[5*SW +: SW] = 7'd100;
        send(d, 1'b1, 1'b0, 7'd64);
        send(d, 1'b0, 1'b0, 7'd127);
        send(d, 1'b0, 1'b1, 7'd127);
        send(d, 1'b1, 1'b0, 7'd127);
        send(d, 1'b0, 1'b1, 7'd0);
        d = fill(0);
        send(d, 1'b1, 1'b1, 7'd0);
        wait_out2();
        check("zero_thr0", {m_tvalid, m_tuser, m_tlast, m_tdata[7:0]}, 11'h710);
        d = fill(0);
        d[CN*SW-SW +: SW] = 7'd127;
        send(d, 1'b0, 1'b0, 7'd0);
        d = fill(5);
        send(d, 1'b0, 1'b0, 7'd0);
        send(d, 1'b1, 1'b1, 7'd0);
        send(d, 1'b0, 1'b0, 7'd0);
        aresetn = 1'b0;
        #1;
        check("flush_tvalid", m_tvalid, 0);
        check("flush_tready", s_tready, 1);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        d = fill(30);
        d[9*SW +: SW] = 7'd31;
        send(d, 1'b0, 1'b0, 7'd50);
        wait_out2();
        check("post_rst", {m_tvalid, m_tdata[7:0]}, 9'h119);
        repeat (3) @(posedge aclk);
        #1;
        lat_mode = 1'b0;
        rand_rdy = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3) == 0 ? 1 : 0) begin
                @(posedge aclk);
                #1;
            end
            for (int k = 0; k < CN; k++)
                d[k*SW +: SW] = SW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 127) : $urandom_range(60, 64));
            send(d, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), SW'($urandom_range(55, 70)));
        end
        rand_rdy = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge aclk);
        #1;
        check("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/video_mnist_result_decoder.md
VIDEO_MNIST_RESULT_DECODER -- requirements
Module: video_mnist_result_decoder

Interface
REQ-001 Parameter TUSER_WIDTH, default 1, width of the tuser sideband carried through unchanged.
REQ-002 Parameter CLASS_NUM, default 10, number of class score fields per pixel, range 2..16.
REQ-003 Parameter SCORE_WIDTH, default 7, unsigned bit width of each class score, range 1..8.
REQ-004 Parameter S_TDATA_WIDTH, default CLASS_NUM*SCORE_WIDTH, input data width; class k occupies bits [k*SCORE_WIDTH +: SCORE_WIDTH].
REQ-005 Parameter M_TDATA_WIDTH, fixed 16, output data width.
REQ-006 Port aclk  input  1  sole clock; all logic is clocked on the rising edge.
REQ-007 Port aresetn  input  1  reset, asynchronous assert, active-low.
REQ-008 Port param_threshold  input  SCORE_WIDTH  minimum winning score for a detection.
REQ-009 Ports s_axi4s_tuser/tlast/tdata/tvalid  input  TUSER_WIDTH/1/S_TDATA_WIDTH/1  per-pixel class-score stream.
REQ-010 Port s_axi4s_tready  output  1  input accept.
REQ-011 Ports m_axi4s_tuser/tlast/tdata/tvalid  output  TUSER_WIDTH/1/16/1  decoded per-pixel stream.
REQ-012 Port m_axi4s_tready  input  1  output accept.

Function
REQ-013 The block SHALL be a 3-stage pipeline; pipeline enable cke = ~m_axi4s_tvalid | m_axi4s_tready, and s_axi4s_tready SHALL equal cke.
REQ-014 Input beats SHALL be accepted when s_axi4s_tvalid & s_axi4s_tready; throughput SHALL be one beat per cycle while m_axi4s_tready is high.
REQ-015 Latency SHALL be exactly 3 cycles from input acceptance to m_axi4s_tvalid with m_axi4s_tready held high.
REQ-016 Stage 1 SHALL register pairwise maxima of adjacent classes (index and score); stage 2 SHALL reduce those to one winner; stage 3 SHALL register the output.
REQ-017 Argmax ties SHALL resolve to the lowest class index; odd CLASS_NUM passes the last class through stage 1 unpaired.
REQ-018 m_axi4s_tdata[3:0] SHALL carry the winning class index; bit [4] the detect flag; bits [7:5] zero.
REQ-019 Detect flag SHALL be 1 when winning score >= the active threshold (unsigned compare), else 0.
REQ-020 The active threshold SHALL be captured from param_threshold on each accepted beat with s_axi4s_tuser[0]=1 and used for that beat and all later beats until the next capture.
REQ-021 tuser and tlast SHALL travel through the pipeline aligned with their beat, unmodified.
REQ-022 When cke is low all stage registers SHALL hold; no beat SHALL be lost or duplicated under any tready pattern.
REQ-023 A stage valid flag SHALL clear on cke when its predecessor holds no valid beat (bubbles propagate).

Reset
REQ-024 On aresetn low all valid flags, m_axi4s_tvalid, m_axi4s_tlast, m_axi4s_tuser, m_axi4s_tdata SHALL be 0 and the active threshold SHALL be 0.
REQ-025 Reset asserted mid-stream SHALL discard all in-flight beats; s_axi4s_tready SHALL be 1 during reset (pipeline empty).
REQ-026 The first accepted beat after reset SHALL emerge 3 cycles later with no stale data.

Configuration
REQ-027 Macro VIDEO_MNIST_RESULT_DECODER_SCORE_EN: when defined, m_axi4s_tdata[15:8] SHALL carry the winning score zero-extended to 8 bits.
REQ-028 Without VIDEO_MNIST_RESULT_DECODER_SCORE_EN, m_axi4s_tdata[15:8] SHALL be constant 0 and the score SHALL not be registered in stage 3.

Verification
REQ-029 Scores class3=100, others 10, threshold 64, tuser=1 -> tdata[4:0]=0x13 after 3 cycles; with SCORE_EN tdata[15:8]=0x64.
REQ-030 Classes 2 and 7 both 90, others 0 -> class 2 reported (lowest index wins).
REQ-031 Threshold 64 latched at frame start, changed to 127 mid-frame, beat max 100 -> detect 1; after next tuser=1 beat with threshold 127 -> detect 0.
REQ-032 Random valid/tready toggling over 1000 beats -> output sequence equals reference model, tlast/tuser aligned, no loss or duplication.
REQ-033 All scores 0, threshold 0 -> class 0, detect 1.
REQ-034 Reset asserted with 3 beats in flight -> m_axi4s_tvalid 0 immediately; next beat after release appears 3 cycles after acceptance.
